tt_um_gate_op_scheduler: RTL and testbench

Time-multiplexed scheduler that shares one 2-input logic unit (AND/NAND/OR/XOR) among four requester lanes. Each lane owns a fixed opcode and one operand pair on `ui_in`. A round-robin arbiter grants one lane at a time, samples its operands, evaluates them through the shared unit and latches a per-lane result with a valid flag. It is a Tiny Tapeout top-level and sits directly on the standard pin harness.

---
 rtl/gate_sched_pkg.sv | 30 +++
 rtl/gate_unit.sv | 22 ++
 rtl/tt_um_gate_op_scheduler.sv | 116 +++++++++++
 tb/tb_tt_um_gate_op_scheduler.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/gate_sched_pkg.sv
// Shared definitions for the four-lane gate-op scheduler: opcodes, lane map, FSM states.
package gate_sched_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 2;
  localparam int unsigned OP_W      = 2;

  localparam logic [OP_W-1:0] OP_AND  = 2'd0;
  localparam logic [OP_W-1:0] OP_NAND = 2'd1;
  localparam logic [OP_W-1:0] OP_OR   = 2'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 2'd3;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // Fixed lane-to-opcode table.
  function automatic logic [OP_W-1:0] lane_op(input logic [LANE_W-1:0] lane);
    logic [OP_W-1:0] op;
    case (lane)
      2'd0:    op = OP_AND;
      2'd1:    op = OP_NAND;
      2'd2:    op = OP_OR;
      default: op = OP_XOR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/gate_unit.sv
// Shared 2-input logic unit evaluating AND/NAND/OR/XOR.
module gate_unit
  import gate_sched_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic            a,
  input  logic            b,
  output logic            out_c
);

  always_comb begin
    out_c = 1'b0;
    case (op)
      OP_AND:  out_c = a & b;
      OP_NAND: out_c = ~(a & b);
      OP_OR:   out_c = a | b;
      OP_XOR:  out_c = a ^ b;
      default: out_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/tt_um_gate_op_scheduler.sv
// Round-robin scheduler sharing one gate unit among four lanes; Tiny Tapeout top.
module tt_um_gate_op_scheduler
  import gate_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  // Returns {found, lane}: first requester at or above ptr, wrapping 3->0.
  function automatic logic [LANE_W:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                               input logic [LANE_W-1:0]    ptr);
    logic [LANE_W:0]   r;
    logic [LANE_W-1:0] idx;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      idx = ptr + LANE_W'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  state_t                state, state_n;
  logic [LANE_W-1:0]     ptr, ptr_n;
  logic [LANE_W-1:0]     lane, lane_n;
  logic [NUM_LANES-1:0]  grant, grant_n;
  logic [NUM_LANES-1:0]  result, result_n;
  logic [NUM_LANES-1:0]  valid, valid_n;
  logic [OP_W-1:0]       opcode, opcode_n;
  logic                  op_a, op_a_n;
  logic                  op_b, op_b_n;
  logic [LANE_W:0]       pick;
  logic                  gate_out;
  logic                  unused_uio;

  assign unused_uio = ^uio_in[7:4];

  gate_unit u_gate_unit (
    .op    (opcode),
    .a     (op_a),
    .b     (op_b),
    .out_c (gate_out)
  );

  // State and datapath registers; ena low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_ARB;
      ptr    <= '0;
      lane   <= '0;
      grant  <= '0;
      result <= '0;
      valid  <= '0;
      opcode <= '0;
      op_a   <= 1'b0;
      op_b   <= 1'b0;
    end else if (ena) begin
      state  <= state_n;
      ptr    <= ptr_n;
      lane   <= lane_n;
      grant  <= grant_n;
      result <= result_n;
      valid  <= valid_n;
      opcode <= opcode_n;
      op_a   <= op_a_n;
      op_b   <= op_b_n;
    end
  end

  // Next-state: arbitrate and capture in ARB, commit the result in EXEC.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    lane_n   = lane;
    grant_n  = grant;
    result_n = result;
    valid_n  = valid;
    opcode_n = opcode;
    op_a_n   = op_a;
    op_b_n   = op_b;
    pick     = rr_pick(uio_in[NUM_LANES-1:0], ptr);

    case (state)
      ST_ARB: begin
        grant_n = '0;
        if (pick[LANE_W]) begin
          lane_n                 = pick[LANE_W-1:0];
          grant_n                = NUM_LANES'(1) << pick[LANE_W-1:0];
          op_a_n                 = ui_in[{pick[LANE_W-1:0], 1'b0}];
          op_b_n                 = ui_in[{pick[LANE_W-1:0], 1'b1}];
          opcode_n               = lane_op(pick[LANE_W-1:0]);
          valid_n[pick[LANE_W-1:0]] = 1'b0;
          state_n                = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_n[lane] = gate_out;
        valid_n[lane]  = 1'b1;
        grant_n        = '0;
        ptr_n          = lane + LANE_W'(1);
        state_n        = ST_ARB;
      end
      default: state_n = ST_ARB;
    endcase
  end

  assign uo_out  = {valid, result};
  assign uio_out = {grant, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_gate_op_scheduler.sv
// Directed vector bench for the gate-op scheduler plus a held-request fairness sequence.
module tb_tt_um_gate_op_scheduler;

  typedef struct packed {
    logic       rst_n;
    logic       ena;
    logic [7:0] ui;
    logic [3:0] req;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int total;
  int bad;
  vec_t vecs[$];

  tt_um_gate_op_scheduler dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%02h expected 0x%02h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [7:0] ui, input logic [3:0] req,
                     input logic [7:0] uo, input logic [7:0] uio);
    vec_t v;
    v.rst_n = r; v.ena = e; v.ui = ui; v.req = req; v.exp_uo = uo; v.exp_uio = uio;
    vecs.push_back(v);
  endtask

  function automatic logic gate_ref(input int lane, input logic a, input logic b);
    case (lane)
      0:       return a & b;
      1:       return ~(a & b);
      2:       return a | b;
      default: return a ^ b;
    endcase
  endfunction

  initial begin
    logic [7:0] u;
    logic [3:0] req;
    logic [3:0] granted;
    logic [3:0] served;
    logic [3:0] res;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ena   = 1'b1;
    ui_in = 8'h00;
    uio_in = 8'h00;

    // reset with random inputs
    add(0, 1, 8'($urandom), 4'($urandom), 8'h00, 8'h00);
    // single XOR lane
    add(1, 1, 8'h40, 4'h8, 8'h00, 8'h80);
    add(1, 1, 8'h40, 4'h8, 8'h88, 8'h00);
    add(1, 1, 8'h40, 4'h0, 8'h88, 8'h00);
    // all four held, ui=FF
    add(1, 1, 8'hFF, 4'hF, 8'h88, 8'h10);
    add(1, 1, 8'hFF, 4'hF, 8'h99, 8'h00);
    add(1, 1, 8'hFF, 4'hF, 8'h99, 8'h20);
    add(1, 1, 8'hFF, 4'hF, 8'hB9, 8'h00);
    add(1, 1, 8'hFF, 4'hF, 8'hB9, 8'h40);
    add(1, 1, 8'hFF, 4'hF, 8'hFD, 8'h00);
    add(1, 1, 8'hFF, 4'hF, 8'h7D, 8'h80);
    add(1, 1, 8'hFF, 4'hF, 8'hF5, 8'h00);
    add(1, 1, 8'hFF, 4'hF, 8'hE5, 8'h10);
    add(1, 1, 8'hFF, 4'hF, 8'hF5, 8'h00);
    // pointer wrap: serve lane 3, then req 0x9 goes to lane 0 first
    add(1, 1, 8'hFF, 4'h8, 8'h75, 8'h80);
    add(1, 1, 8'hFF, 4'h8, 8'hF5, 8'h00);
    add(1, 1, 8'h03, 4'h9, 8'hE5, 8'h10);
    // operands change during EXEC: sampled a0=b0=1 still wins
    add(1, 1, 8'h00, 4'h9, 8'hF5, 8'h00);
    add(1, 1, 8'h00, 4'h9, 8'h75, 8'h80);
    add(1, 1, 8'h00, 4'h9, 8'hF5, 8'h00);
    // freeze during EXEC
    add(1, 1, 8'h00, 4'h1, 8'hE5, 8'h10);
    add(1, 0, 8'hFF, 4'h0, 8'hE5, 8'h10);
    add(1, 0, 8'hFF, 4'h0, 8'hE5, 8'h10);
    add(1, 0, 8'hFF, 4'h0, 8'hE5, 8'h10);
    add(1, 1, 8'hFF, 4'h0, 8'hF4, 8'h00);
    // reset mid-EXEC
    add(1, 1, 8'hFF, 4'h2, 8'hD4, 8'h20);
    add(0, 1, 8'hFF, 4'h2, 8'h00, 8'h00);
    add(1, 1, 8'hFF, 4'h0, 8'h00, 8'h00);
    // after reset ptr is 0; lane 2 then lane 3 from ptr 3
    add(1, 1, 8'h10, 4'h4, 8'h00, 8'h40);
    add(1, 1, 8'h10, 4'h4, 8'h44, 8'h00);
    add(1, 1, 8'h00, 4'hF, 8'h44, 8'h80);
    add(1, 1, 8'h00, 4'h0, 8'hC4, 8'h00);

    foreach (vecs[i]) begin
      rst_n  = vecs[i].rst_n;
      ena    = vecs[i].ena;
      ui_in  = vecs[i].ui;
      uio_in = {4'($urandom), vecs[i].req};
      @(posedge clk);
      #1;
      check("uo_out", i, uo_out, vecs[i].exp_uo);
      check("uio_out", i, uio_out, vecs[i].exp_uio);
      check("uio_oe", i, uio_oe, 8'hF0);
    end

    // All four requests held under the requester protocol: each served within 8 cycles.
    rst_n   = 1'b1;
    ena     = 1'b1;
    u       = 8'($urandom);
    ui_in   = u;
    req     = 4'hF;
    granted = '0;
    served  = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      uio_in = {4'h0, req};
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (granted[k] && uo_out[4+k] && !served[k]) begin
          served[k] = 1'b1;
          req[k]    = 1'b0;
        end
        if (uio_out[4+k]) granted[k] = 1'b1;
      end
    end
    uio_in = 8'h00;
    check("rr_served", 0, {4'h0, served}, 8'h0F);
    for (int k = 0; k < 4; k++) res[k] = gate_ref(k, u[2*k], u[2*k+1]);
    check("rr_uo_out", 0, uo_out, {4'hF, res});
    check("rr_uio_out", 0, uio_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
